// File: rtl/ex_hazard_ctrl_if.sv
// ex_hazard_ctrl_if: decode/execute/memory handshake and forwarding bundle for the EX hazard controller.
interface ex_hazard_ctrl_if;
    logic [31:0] id_ir;
    logic        id_v;
    logic        id_r;
    logic        issue_v;
    logic        ex_r;
    logic        stall;
    logic        ex_v;
    logic [31:0] ex_ir;
    logic [31:0] ex_alu;
    logic [31:0] ex_pc;
    logic        ex_comp;
    logic        mem_v;
    logic [31:0] mem_data;
    logic [4:0]  aa;
    logic [31:0] fa;
    logic [4:0]  am;
    logic [31:0] fm;
    logic        flush;

    modport slave (
        input  id_ir, id_v, ex_r, ex_v, ex_ir, ex_alu, ex_pc, ex_comp, mem_v, mem_data,
        output id_r, issue_v, stall, aa, fa, am, fm, flush
    );

    modport master (
        output id_ir, id_v, ex_r, ex_v, ex_ir, ex_alu, ex_pc, ex_comp, mem_v, mem_data,
        input  id_r, issue_v, stall, aa, fa, am, fm, flush
    );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: RV32I execute-stage issue gating, EX/MEM forwarding, load-use stall and branch flush.
// Optional HAZ_PERF_EN adds saturating stall_cnt/flush_cnt performance counters.
module ex_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2
`ifdef HAZ_PERF_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic clk,
    input  logic rst_n,
    ex_hazard_ctrl_if.slave bus
`ifdef HAZ_PERF_EN
    , output logic [CNT_W-1:0] stall_cnt
    , output logic [CNT_W-1:0] flush_cnt
`endif
);
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_OP = 7'b0110011;

    typedef enum logic [1:0] {RUN, LDSTALL, FLUSH} state_t;

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic       pend_v;
    logic [4:0] pend_rd;
    logic [6:0] id_op, ex_op;
    logic [4:0] ex_rd, rs1, rs2;
    logic       rd_rs1, rd_rs2, ex_wr, hazard, trig;

    assign id_op  = bus.id_ir[6:0];
    assign rs1    = bus.id_ir[19:15];
    assign rs2    = bus.id_ir[24:20];
    assign ex_op  = bus.ex_ir[6:0];
    assign ex_rd  = bus.ex_ir[11:7];
    assign rd_rs1 = id_op inside {OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_OP};
    assign rd_rs2 = id_op inside {OP_BRANCH, OP_STORE, OP_OP};
    assign ex_wr  = ex_op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_OP};
    // pend_rd is never x0, so x0 sources cannot match
    assign hazard = pend_v && bus.id_v && ((rd_rs1 && rs1 == pend_rd) || (rd_rs2 && rs2 == pend_rd));
    assign trig   = bus.ex_v && (ex_op == OP_JAL || ex_op == OP_JALR || (ex_op == OP_BRANCH && bus.ex_comp));

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        bus.issue_v = 1'b0;
        bus.id_r    = 1'b0;
        bus.stall   = 1'b0;
        bus.flush   = 1'b0;
        case (state)
            RUN: begin
                bus.issue_v = bus.id_v && !hazard;
                bus.id_r    = bus.ex_r && !hazard;
                bus.stall   = hazard;
                // data arriving in the hazard cycle already lands on am/fm next cycle
                if (hazard && !bus.mem_v) state_nx = LDSTALL;
            end
            LDSTALL: begin
                bus.stall = 1'b1;
                if (bus.mem_v) state_nx = RUN;
            end
            FLUSH: begin
                bus.id_r  = 1'b1;
                bus.flush = 1'b1;
                cnt_nx    = cnt - 4'd1;
                if (cnt == 4'd1) state_nx = RUN;
            end
            default: state_nx = RUN;
        endcase
        if (trig) begin
            state_nx = FLUSH;
            cnt_nx   = 4'(FLUSH_CYCLES);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= RUN;
            cnt     <= '0;
            pend_v  <= 1'b0;
            pend_rd <= '0;
            bus.aa  <= '0;
            bus.fa  <= '0;
            bus.am  <= '0;
            bus.fm  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (bus.mem_v && pend_v) begin
                bus.am <= pend_rd;
                bus.fm <= bus.mem_data;
                pend_v <= 1'b0;
            end else begin
                bus.am <= bus.aa;
                bus.fm <= bus.fa;
            end
            if (bus.ex_v && ex_op == OP_LOAD && ex_rd != 5'd0) begin
                pend_v  <= 1'b1;
                pend_rd <= ex_rd;
            end
            bus.aa <= (bus.ex_v && ex_wr && ex_op != OP_LOAD) ? ex_rd : 5'd0;
            if (bus.ex_v && ex_wr && ex_op != OP_LOAD)
                bus.fa <= (ex_op == OP_JAL || ex_op == OP_JALR) ? bus.ex_pc : bus.ex_alu;
        end
    end

`ifdef HAZ_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (bus.stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (trig && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`endif
endmodule
